cosim_commit_reg_checker: RTL



---
 rtl/cosim_commit_reg_checker.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cosim_commit_reg_checker.sv
// Checks DUT register-write beats against a per-instruction reference write log,
// matching items regardless of order and reporting pass/fail with a sticky fail flag.
module cosim_commit_reg_checker #(
    parameter int CommitLogEntries = 16,
    parameter int FifoDepth        = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            dut_wr_valid_i,
    output logic                            dut_wr_ready_o,
    input  logic                            dut_wr_en_i,
    input  logic                            dut_wr_last_i,
    input  logic [63:0]                     dut_wr_key_i,
    input  logic [127:0]                    dut_wr_value_i,
    input  logic                            ref_valid_i,
    output logic                            ref_ready_o,
    input  logic [7:0]                      ref_count_i,
    input  logic [CommitLogEntries*64-1:0]  ref_key_i,
    input  logic [CommitLogEntries*128-1:0] ref_value_i,
    output logic                            done_o,
    output logic                            pass_o,
    output logic [2:0]                      err_code_o,
    output logic [63:0]                     err_key_o,
    output logic [31:0]                     instr_cnt_o,
    output logic                            fail_o
);
    localparam int FW  = $clog2(FifoDepth);
    localparam int FW1 = FW + 1;
    localparam int IW  = $clog2(CommitLogEntries);
    localparam int CW  = $clog2(CommitLogEntries + 1);

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_EXTRA   = 3'd1;
    localparam logic [2:0] E_VALUE   = 3'd2;
    localparam logic [2:0] E_MISSING = 3'd3;
    localparam logic [2:0] E_COUNT   = 3'd4;

    typedef struct packed {
        logic         en;
        logic         last;
        logic [63:0]  key;
        logic [127:0] value;
    } beat_t;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    beat_t                       r_mem [FifoDepth];
    logic [FW-1:0]               r_wptr;
    logic [FW-1:0]               r_rptr;
    logic [FW:0]                 r_fill;
    logic                        r_full;
    logic                        w_push;
    logic                        w_pop;
    logic [FW:0]                 w_fill_nxt;
    beat_t                       w_in;
    beat_t                       w_beat;

    logic [63:0]                 r_ref_key [CommitLogEntries];
    logic [127:0]                r_ref_val [CommitLogEntries];
    logic [CW-1:0]               r_ref_cnt;
    logic [CommitLogEntries-1:0] r_matched;
    logic [2:0]                  r_err;
    logic [63:0]                 r_ekey;
    logic [2:0]                  r_err_code;
    logic [63:0]                 r_err_key;
    logic [31:0]                 r_instr;
    logic                        r_fail;

    logic                        w_ref_hs;
    logic [CommitLogEntries-1:0] w_in_range;
    logic [CommitLogEntries-1:0] w_cand;
    logic                        w_hit;
    logic [IW-1:0]               w_hit_idx;
    logic [3:0]                  w_type;
    logic                        w_full_cmp;
    logic [127:0]                w_hit_val;
    logic                        w_val_diff;
    logic [CommitLogEntries-1:0] w_matched_nxt;
    logic [CommitLogEntries-1:0] w_miss;
    logic [IW-1:0]               w_miss_idx;
    logic [2:0]                  w_err_nxt;
    logic [63:0]                 w_ekey_nxt;

    // Beat FIFO: full flag is registered so ready never depends on a same-cycle pop.
    assign dut_wr_ready_o = !r_full;
    assign w_push         = dut_wr_valid_i && !r_full;
    assign w_pop          = (r_state == S_CHECK) && (r_fill != '0);
    assign w_fill_nxt     = r_fill + FW1'(w_push) - FW1'(w_pop);
    assign w_beat         = r_mem[r_rptr];
    assign w_in           = '{en: dut_wr_en_i, last: dut_wr_last_i,
                              key: dut_wr_key_i, value: dut_wr_value_i};

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= w_in;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_fill <= w_fill_nxt;
            r_full <= (w_fill_nxt == FW1'(FifoDepth));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ref_ready_o = 1'b0;
        done_o      = 1'b0;
        pass_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ref_ready_o = 1'b1;
                if (ref_valid_i) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_pop && w_beat.last) w_state_nxt = S_REPORT;
            end
            S_REPORT: begin
                done_o      = 1'b1;
                pass_o      = (r_err_code == E_NONE);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ref_hs = ref_valid_i && ref_ready_o;

    always_ff @(posedge clk_i) begin
        if (w_ref_hs) begin
            for (int i = 0; i < CommitLogEntries; i++) begin
                r_ref_key[i] <= ref_key_i[64*i +: 64];
                r_ref_val[i] <= ref_value_i[128*i +: 128];
            end
        end
    end

    // Candidate search: lowest unmatched in-range reference item with an equal key.
    always_comb begin
        w_in_range = '0;
        w_cand     = '0;
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        for (int i = 0; i < CommitLogEntries; i++) begin
            w_in_range[i] = (CW'(i) < r_ref_cnt);
            w_cand[i]     = w_in_range[i] && !r_matched[i] && (r_ref_key[i] == w_beat.key);
        end
        for (int i = CommitLogEntries - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
        end
    end

    // FREG/VREG/VREG_HINT compare all 128 bits; XREG and CSR only the low 64.
    assign w_type     = w_beat.key[3:0];
    assign w_full_cmp = (w_type == 4'd1) || (w_type == 4'd2) || (w_type == 4'd3);
    assign w_hit_val  = r_ref_val[w_hit_idx];
    assign w_val_diff = w_full_cmp ? (w_hit_val != w_beat.value)
                                   : (w_hit_val[63:0] != w_beat.value[63:0]);

    always_comb begin
        w_matched_nxt = r_matched;
        w_err_nxt     = r_err;
        w_ekey_nxt    = r_ekey;
        w_miss_idx    = '0;
        if (w_beat.en) begin
            if (!w_hit) begin
                if (r_err == E_NONE) begin
                    w_err_nxt  = E_EXTRA;
                    w_ekey_nxt = w_beat.key;
                end
            end else begin
                w_matched_nxt[w_hit_idx] = 1'b1;
                if (w_val_diff && (r_err == E_NONE)) begin
                    w_err_nxt  = E_VALUE;
                    w_ekey_nxt = w_beat.key;
                end
            end
        end
        w_miss = w_in_range & ~w_matched_nxt;
        for (int i = CommitLogEntries - 1; i >= 0; i--) begin
            if (w_miss[i]) w_miss_idx = IW'(i);
        end
        if (w_beat.last && (w_err_nxt == E_NONE) && (|w_miss)) begin
            w_err_nxt  = E_MISSING;
            w_ekey_nxt = r_ref_key[w_miss_idx];
        end
    end

    // Result registers update on the last beat so they are valid alongside done_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ref_cnt  <= '0;
            r_matched  <= '0;
            r_err      <= E_NONE;
            r_ekey     <= '0;
            r_err_code <= E_NONE;
            r_err_key  <= '0;
            r_instr    <= '0;
            r_fail     <= 1'b0;
        end else if (w_ref_hs) begin
            r_matched <= '0;
            r_ekey    <= '0;
            if (ref_count_i > 8'(CommitLogEntries)) begin
                r_ref_cnt <= '0;
                r_err     <= E_COUNT;
            end else begin
                r_ref_cnt <= ref_count_i[CW-1:0];
                r_err     <= E_NONE;
            end
        end else if (w_pop) begin
            r_matched <= w_matched_nxt;
            r_err     <= w_err_nxt;
            r_ekey    <= w_ekey_nxt;
            if (w_beat.last) begin
                r_err_code <= w_err_nxt;
                r_err_key  <= w_ekey_nxt;
                r_instr    <= r_instr + 32'd1;
                r_fail     <= r_fail | (w_err_nxt != E_NONE);
            end
        end
    end

    assign err_code_o  = r_err_code;
    assign err_key_o   = r_err_key;
    assign instr_cnt_o = r_instr;
    assign fail_o      = r_fail;

endmodule
